ctrl_if: RTL
============

// Module: ctrl_if
// PURPOSE
//  Instruction-fetch stage of the 16-bit pipelined core; sits directly upstream of the ID stage
//  and produces the instruction word consumed by control's i_ir_id. Holds the fetch PC, issues
//  halfword reads to instruction memory over a req/ack handshake and buffers prefetched words
//  in a small FIFO. Applies branch redirects (addr_mode) and honours the ID-stage stall.
// PARAMETERS
//  AW         16       fetch address width (byte address, halfword aligned)
//  DEPTH      2        prefetch FIFO entries (power of 2, >=2)
//  RESET_VEC  'h0000   first fetch address after reset
// PORTS
//  clk            in   1    clock, rising edge
//  rst            in   1    asynchronous reset, active-low (asserted at 0)
//  i_stall        in   1    ID stall (o_stall_id); 1 = hold o_ir_r/o_pc_r/o_ir_valid_r
//  i_addr_mode    in   2    00 sequential, 01 redirect to i_branch_addr, 1x reserved (= 00)
//  i_branch_addr  in   AW   redirect target from ALU
//  i_mem_busy     in   1    data-side memory access in progress; no new fetch request issued
//  o_imem_req     out  1    fetch request, held until ack
//  o_imem_addr    out  AW   fetch address, stable while o_imem_req=1
//  i_imem_ack     in   1    read data valid this cycle; completes the outstanding request
//  i_imem_data    in   16   instruction halfword
//  o_ir_r         out  16   instruction to ID stage (registered)
//  o_ir_valid_r   out  1    o_ir_r holds a real instruction (0 = bubble)
//  o_pc_r         out  AW   address of o_ir_r
// BEHAVIOUR
//  Reset (async, rst=0): fetch_pc=RESET_VEC, FIFO empty, o_imem_req=0, o_imem_addr=RESET_VEC,
//   o_ir_r=NOP_INSTR, o_ir_valid_r=0, o_pc_r=0, state=IDLE. Reset mid-request drops it silently.
//  FSM: IDLE -> FETCH on first clock after rst release.
//   FETCH: req=1 when (fifo_count + outstanding) < DEPTH and i_mem_busy=0; at most one request
//    outstanding. Request never withdrawn once raised (i_mem_busy ignored after raise).
//    On ack: push {data, addr} into FIFO, fetch_pc += 2 (wraps mod 2^AW), req may re-assert
//    next cycle if space remains.
//   DISCARD: entered on redirect while a request is outstanding and not acked that cycle;
//    req held to the old address, ack data dropped, then -> FETCH at the new fetch_pc.
//  Output register (non-redirect cycles): i_stall=1 -> hold all three outputs. i_stall=0 and
//   FIFO non-empty -> pop into o_ir_r/o_pc_r, o_ir_valid_r=1. i_stall=0 and empty -> NOP_INSTR,
//   valid=0, o_pc_r held. No FIFO bypass: ack at edge k is visible on o_ir_r at edge k+1 earliest.
//  Redirect (i_addr_mode==01), highest priority, overrides i_stall:
//   FIFO flushed; o_ir_r=NOP_INSTR, o_ir_valid_r=0; fetch_pc=i_branch_addr with bit0 cleared.
//   Ack in the same cycle: data dropped, state FETCH, new request next cycle from target.
//   Ack not yet received: -> DISCARD. Consecutive redirects: latest target wins.
//  Simultaneous push and pop: both performed, count unchanged. Push when full is impossible by
//   the credit rule; verification asserts it never happens.
// STRUCTURE
//  cpu_pkg: NOP_INSTR = 16'h0000; addr_mode constants ADDR_SEQ=2'b00, ADDR_ALU=2'b01;
//   typedef enum {IF_IDLE, IF_FETCH, IF_DISCARD} if_state_t.
//  Sub-module if_fifo: sync FIFO, DEPTH x (16+AW), push/pop/flush, count, full/empty flags.
//  ctrl_if keeps the FSM, fetch PC, credit counter and output register.
// TESTING
//  1 Reset release, ack 1 cycle after each req, mem data 0x1001,0x1002.. -> addrs 0,2,4..,
//    o_ir_r 0x1001 valid=1 with o_pc_r=0, one instr per cycle steady-state.
//  2 i_stall=1 for 3 cycles with FIFO full -> outputs held, req=0 until a pop frees a slot.
//  3 Redirect to 0x0041 with FIFO holding 2 words -> next o_ir_r NOP valid=0, next req addr 0x0040.
//  4 Redirect while req outstanding, ack 2 cycles later with 0xDEAD -> 0xDEAD never on o_ir_r,
//    next req addr = target.
//  5 i_mem_busy=1 for 4 cycles with FIFO empty -> req=0, o_ir_valid_r=0 bubbles; resume after.
//  6 fetch_pc=2^AW-2 sequential -> next fetch addr 0; rst=0 mid-request -> outputs reset at once.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-side constants and types.
// Used by the IF stage and its prefetch FIFO.
package cpu_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam logic [1:0] ADDR_SEQ = 2'b00;
  localparam logic [1:0] ADDR_ALU = 2'b01;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_FETCH,
    IF_DISCARD
  } if_state_t;

endpackage

// File: rtl/ctrl_if_if.sv
// Instruction memory req/ack bus.
// Master is the fetch stage, slave is the memory.
interface ctrl_if_if #(
  parameter int AW = 16
);

  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic [15:0]   data;

  modport master (
    output req,
    output addr,
    input  ack,
    input  data
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output data
  );

endinterface

// File: rtl/ctrl_if_fifo.sv
// Prefetch FIFO: holds {instr, pc} words.
// Power-of-two depth, flush clears all entries.
module if_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; count gates reads.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ctrl_if.sv
// IF stage: fetch PC, imem req/ack, prefetch
// FIFO and the registered instruction to ID.
module ctrl_if
  import cpu_pkg::*;
#(
  parameter int            AW        = 16,
  parameter int            DEPTH     = 2,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_stall,
  input  logic [1:0]    i_addr_mode,
  input  logic [AW-1:0] i_branch_addr,
  input  logic          i_mem_busy,
  ctrl_if_if.master     imem,
  output logic [15:0]   o_ir_r,
  output logic          o_ir_valid_r,
  output logic [AW-1:0] o_pc_r
);

  localparam int FW = 16 + AW;
  localparam int CW = $clog2(DEPTH) + 1;

  if_state_t     state;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] pc_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [FW-1:0] rdata;
  logic          full;
  logic          empty;
  logic          redirect;
  logic          acked;
  logic          held;
  logic          push;
  logic          pop;
  logic          issue;

  assign redirect = (i_addr_mode == ADDR_ALU);
  assign acked    = imem.req && imem.ack;
  assign held     = imem.req && !imem.ack;
  assign push     = acked && (state == IF_FETCH)
                    && !redirect;
  assign pop      = !redirect && !i_stall && !empty;

  if_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({imem.data, imem.addr}),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Occupancy and PC as they will be after this edge.
  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
    pc_next    = push ? fetch_pc + AW'(2) : fetch_pc;
    if (redirect) begin
      count_next = '0;
      pc_next    = i_branch_addr & ~AW'(1);
    end
  end

  // Credit rule: a new request only if its word has a slot.
  assign issue = !held && (state != IF_IDLE)
                 && !i_mem_busy
                 && (count_next < CW'(DEPTH));

  // Fetch FSM, fetch PC and request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IF_IDLE;
      fetch_pc  <= RESET_VEC;
      imem.req  <= 1'b0;
      imem.addr <= RESET_VEC;
    end else begin
      fetch_pc <= pc_next;
      imem.req <= held || issue;
      if (issue) imem.addr <= pc_next;
      unique case (state)
        IF_IDLE:    state <= IF_FETCH;
        IF_FETCH:   if (redirect && held)
                      state <= IF_DISCARD;
        IF_DISCARD: if (acked)
                      state <= IF_FETCH;
        default:    state <= IF_IDLE;
      endcase
    end
  end

  // Instruction register toward ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_ir_r       <= NOP_INSTR;
      o_ir_valid_r <= 1'b0;
      o_pc_r       <= '0;
    end else if (redirect) begin
      o_ir_r       <= NOP_INSTR;
      o_ir_valid_r <= 1'b0;
    end else if (!i_stall) begin
      if (!empty) begin
        o_ir_r       <= rdata[FW-1:AW];
        o_pc_r       <= rdata[AW-1:0];
        o_ir_valid_r <= 1'b1;
      end else begin
        o_ir_r       <= NOP_INSTR;
        o_ir_valid_r <= 1'b0;
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && full)
  );

endmodule
